// File: rtl/comp_sort_ctrl.sv
// Batch sorter: loads DEPTH unsigned bytes, bubble-sorts them in place with one
// shared comparator, then streams them out. Define SORT_STATS_EN to add swap/compare counters.
module comp_sort_ctrl #(
  parameter int DEPTH   = 8,
  parameter int DESCEND = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done
`ifdef SORT_STATS_EN
  ,
  output logic [7:0] swap_cnt,
  output logic [7:0] cmp_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam logic [SW-1:0] LAST_PASS = SW'(DEPTH - 2);

  typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_OUT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, j, j_nxt;
  logic [SW-1:0] pass;
  logic          swapped, started;
  logic [7:0]    cmp_a, cmp_b;
  logic          gt, lt, eq;
  logic          accept, pass_end, swap_en;

  assign j_nxt = j + PW'(1);
  assign cmp_a = data_mem[j];
  assign cmp_b = data_mem[j_nxt];

  // The single shared comparator: purely combinational, unsigned.
  always_comb begin : compare_8bits
    gt = (cmp_a > cmp_b);
    lt = (cmp_a < cmp_b);
    eq = (cmp_a == cmp_b);
  end

  assign accept   = in_valid && in_ready;
  assign pass_end = ({1'b0, j} + (PW+1)'(pass)) == (PW+1)'(DEPTH - 2);

  assign in_ready  = (state_q == ST_LOAD) && started;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = (state_q == ST_OUT) ? data_mem[rd_ptr] : 8'd0;
  assign busy      = (state_q != ST_LOAD);
  assign done      = (state_q == ST_OUT) && out_ready && (rd_ptr == LAST_IDX);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    swap_en = 1'b0;
    case (state_q)
      ST_LOAD: if (accept && wr_ptr == LAST_IDX) state_d = ST_SORT;
      ST_SORT: begin
        // Equal pairs never swap, which keeps the sort stable.
        swap_en = !eq && ((DESCEND != 0) ? lt : gt);
        if (pass_end && (!(swapped || swap_en) || pass == LAST_PASS)) state_d = ST_OUT;
      end
      ST_OUT:  if (out_ready && rd_ptr == LAST_IDX) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      started <= 1'b0;
    end else begin
      state_q <= state_d;
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the sample buffer is small and must read as zero after reset, so it is reset explicitly.
      for (int i = 0; i < DEPTH; i++) data_mem[i] <= 8'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      j       <= '0;
      pass    <= '0;
      swapped <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            data_mem[wr_ptr] <= in_data;
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PW'(1);
          end
          j       <= '0;
          pass    <= '0;
          swapped <= 1'b0;
          rd_ptr  <= '0;
        end
        ST_SORT: begin
          if (swap_en) begin
            data_mem[j]     <= cmp_b;
            data_mem[j_nxt] <= cmp_a;
          end
          if (pass_end) begin
            j       <= '0;
            pass    <= pass + SW'(1);
            swapped <= 1'b0;
          end else begin
            j       <= j_nxt;
            swapped <= swapped || swap_en;
          end
          rd_ptr <= '0;
        end
        ST_OUT: if (out_ready) rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PW'(1);
        default: ;
      endcase
    end
  end

`ifdef SORT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt <= 8'd0;
      cmp_cnt  <= 8'd0;
    end else if (state_q == ST_LOAD && state_d == ST_SORT) begin
      swap_cnt <= 8'd0;
      cmp_cnt  <= 8'd0;
    end else if (state_q == ST_SORT) begin
      cmp_cnt <= cmp_cnt + 8'd1;
      if (swap_en) swap_cnt <= swap_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/comp_sort_ctrl.md
Name: comp_sort_ctrl

Overview:
- Sequencer that buffers DEPTH unsigned 8-bit samples, then sorts them in place using one shared compare_8bits instance (one compare per cycle, bubble sort with early exit).
- Streams the sorted result out.
- Sits between a sample source and a consumer wherever ordered data (median, min/max, ranking) is required.
- The comparator stays purely combinational; this block owns all sequencing and storage.

Parameters:
- DEPTH, 8, number of samples per sort batch; legal range 2..16.
- DESCEND, 0, 0 = ascending output order, 1 = descending.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  source presents in_data
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  8  unsigned sample
- out_valid  output  1  out_data holds a sorted sample
- out_ready  input  1  consumer accepts out_data
- out_data  output  8  sorted sample, element 0 first
- busy  output  1  high in SORT and OUT
- done  output  1  one-cycle pulse on the final output handshake

Behaviour:
- Reset (async, rst_n=0) forces:
  - State LOAD; buffer, pointers and flags cleared.
  - in_ready=0 during reset, 1 on the first clock after release.
  - out_valid=0, out_data=0, busy=0, done=0.
- Reset asserted mid-SORT or mid-OUT aborts the batch; no partial output follows.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready handshake writes buf[wr_ptr] and increments wr_ptr.
  - The handshake with wr_ptr=DEPTH-1 moves the FSM to SORT on the next edge and clears wr_ptr.
- SORT:
  - in_ready=0, busy=1.
  - Comparator inputs: a=buf[j], b=buf[j+1].
  - Swap condition: gt when DESCEND=0, lt when DESCEND=1. eq never swaps, so the sort is stable.
  - Swap takes effect at the same edge.
  - Inner index j runs 0..DEPTH-2-pass. At the end of a pass:
    - If no swap occurred in the pass, or pass=DEPTH-2, go to OUT.
    - Otherwise pass++, j=0, swap flag cleared.
  - Compare cycles: already-ordered input takes exactly DEPTH-1 SORT cycles. Worst case is DEPTH*(DEPTH-1)/2 cycles: 7 and 28 for DEPTH=8.
- OUT:
  - out_valid=1, out_data=buf[rd_ptr] (registered, rd_ptr starts at 0).
  - On out_valid&out_ready, rd_ptr increments and out_data updates next cycle.
  - out_ready=0 holds out_data and out_valid stable.
  - The handshake at rd_ptr=DEPTH-1 pulses done for one cycle and returns to LOAD. out_valid drops the next cycle; in_ready rises the same cycle.
- No overlap: a new batch is not accepted until OUT completes.
- in_valid is ignored outside LOAD; out_ready is ignored outside OUT.
- Arithmetic: unsigned 8-bit compare only. Pointers are $clog2(DEPTH) bits; the pass counter is sized for DEPTH-2.

Optional Feature:
- Macro SORT_STATS_EN.
- When defined, two outputs are added:
  - swap_cnt[7:0]: swaps in the current batch, cleared on entry to SORT.
  - cmp_cnt[7:0]: compare cycles in the current batch, cleared on entry to SORT.
  - Both hold their values through OUT until the next SORT entry; both reset to 0.
- When undefined, the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Ascending load 1,2,...,8, DESCEND=0 -> exactly 7 SORT cycles, output 1..8, done pulse on 8th handshake; stats: cmp_cnt=7, swap_cnt=0.
- Descending load 8,7,...,1 -> 28 SORT cycles, output 1..8; stats: cmp_cnt=28, swap_cnt=28.
- Boundary values 0xFF,0x00,0x80,0x7F,0x01,0xFE,0x7F,0x80 -> output 00,01,7F,7F,80,80,FE,FF (unsigned order); same set with DESCEND=1 -> reversed.
- Duplicates 5,3,5,3,5,3,5,3 -> output 3,3,3,3,5,5,5,5; no swaps of equal pairs.
- Backpressure: out_ready toggled 0/1 every other cycle -> out_data stable while out_ready=0, no sample lost or repeated; in_valid held high during OUT accepts nothing.
- Reset mid-SORT (rst_n low 2 cycles at SORT cycle 10) -> outputs at reset values immediately, in_ready=1 after release, new batch sorted correctly.
